attempt_guard: RTL and testbench

Parametrised failed-attempt supervisor for the six-digit lock controller. It sits between the code comparator and the unlock/alarm logic. It consumes one verdict strobe per entered code and counts consecutive failures up to a configurable limit. On reaching the limit it imposes a timed lockout whose length doubles on each repeated lockout, up to a cap. Unlike the earlier fixed 2-bit counter, it is fully synchronous to one clock, saturates at a parameter, enforces lockout itself and supports administrator clear.

---
 rtl/lock_pkg.sv | 12 +
 rtl/attempt_guard_if.sv | 24 ++
 rtl/attempt_guard_lockout_timer.sv | 33 +++
 rtl/attempt_guard.sv | 124 ++++++++++++
 tb/tb_attempt_guard.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller: guard FSM states and the
// escalation-level width also used by the lockout-time display driver.
package lock_pkg;

    localparam int LEVEL_W = 2;

    typedef enum logic {
        G_NORMAL  = 1'b0,
        G_LOCKOUT = 1'b1
    } guard_state_e;

endpackage

// File: rtl/attempt_guard_if.sv
// Verdict handshake between the code comparator (master) and the attempt
// guard (slave).
// Handshake: verdict_valid is a one-cycle strobe carrying verdict_ok; the
// slave raises ready while it will act on a verdict. A strobe seen while
// ready=0 is not acted on (the guard flags it as rejected) and is not retried.
interface attempt_guard_if;

    logic verdict_valid;
    logic verdict_ok;
    logic ready;

    modport master (
        output verdict_valid,
        output verdict_ok,
        input  ready
    );

    modport slave (
        input  verdict_valid,
        input  verdict_ok,
        output ready
    );

endinterface

// File: rtl/attempt_guard_lockout_timer.sv
// Loadable down-counter that times a lockout; done flags the final cycle.
module lockout_timer #(
    parameter int TMR_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             count,
    output logic [TMR_W-1:0] remaining,
    output logic             done
);

    // Clear beats load beats count; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (count && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Last locked cycle: the next edge ends the lockout.
    always_comb begin
        done = (remaining == TMR_W'(1));
    end

endmodule

// File: rtl/attempt_guard.sv
// Failed-attempt supervisor: counts consecutive failed codes, imposes an
// escalating timed lockout, and rejects verdicts that arrive while locked.
module attempt_guard
    import lock_pkg::*;
#(
    parameter int MAX_ERR     = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int MAX_LEVEL   = 3,
    parameter int CNT_W       = $clog2(MAX_ERR + 1),
    parameter int TMR_W       = $clog2((LOCK_CYCLES << MAX_LEVEL) + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    attempt_guard_if.slave       vif,
    input  logic                 admin_clear,
    output logic [CNT_W-1:0]     err_count,
    output logic                 locked,
    output logic [TMR_W-1:0]     lock_remaining,
    output logic [LEVEL_W-1:0]   level,
    output logic                 alarm,
    output logic                 rejected,
    output guard_state_e         state
);

    guard_state_e       state_q, state_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               alarm_q, alarm_d;
    logic               rejected_q, rejected_d;
    logic               tmr_clear, tmr_load, tmr_count, tmr_done;
    logic [TMR_W-1:0]   tmr_load_val;

    lockout_timer #(.TMR_W(TMR_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .load      (tmr_load),
        .load_val  (tmr_load_val),
        .count     (tmr_count),
        .remaining (lock_remaining),
        .done      (tmr_done)
    );

    // State, counters and the one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= G_NORMAL;
            err_q      <= '0;
            level_q    <= '0;
            alarm_q    <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            level_q    <= level_d;
            alarm_q    <= alarm_d;
            rejected_q <= rejected_d;
        end
    end

    // Next state: admin_clear overrides everything, including a same-cycle verdict.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        level_d      = level_q;
        alarm_d      = 1'b0;
        rejected_d   = 1'b0;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_count    = 1'b0;
        tmr_load_val = TMR_W'(LOCK_CYCLES) << level_q;
        if (admin_clear) begin
            state_d   = G_NORMAL;
            err_d     = '0;
            level_d   = '0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                G_NORMAL: begin
                    if (vif.verdict_valid) begin
                        if (vif.verdict_ok) begin
                            err_d   = '0;
                            level_d = '0;
                        end else if (err_q == CNT_W'(MAX_ERR - 1)) begin
                            // Limit reached: lockout length uses the level before escalation.
                            err_d    = CNT_W'(MAX_ERR);
                            state_d  = G_LOCKOUT;
                            tmr_load = 1'b1;
                            alarm_d  = 1'b1;
                            if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                                level_d = level_q + 1'b1;
                            end
                        end else begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
                G_LOCKOUT: begin
                    tmr_count  = 1'b1;
                    rejected_d = vif.verdict_valid;
                    if (tmr_done) begin
                        state_d = G_NORMAL;
                        err_d   = '0;
                    end
                end
                default: begin
                    state_d = G_NORMAL;
                end
            endcase
        end
    end

    // Registered outputs decoded from the state and counter registers.
    always_comb begin
        locked    = (state_q == G_LOCKOUT);
        vif.ready = !locked;
        err_count = err_q;
        level     = level_q;
        alarm     = alarm_q;
        rejected  = rejected_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_attempt_guard.sv
// Bench for attempt_guard with MAX_ERR=3, LOCK_CYCLES=8, MAX_LEVEL=3.
module tb_attempt_guard;
    import lock_pkg::*;

    localparam int MAX_ERR     = 3;
    localparam int LOCK_CYCLES = 8;
    localparam int MAX_LEVEL   = 3;
    localparam int CNT_W       = 2;
    localparam int TMR_W       = 7;
    localparam int EXP_W       = 2 + CNT_W + TMR_W + 2 + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic admin_clear;
    logic [CNT_W-1:0] err_count;
    logic locked;
    logic [TMR_W-1:0] lock_remaining;
    logic [1:0] level;
    logic alarm;
    logic rejected;
    guard_state_e state;

    always #5 clk = ~clk;

    attempt_guard_if vif();

    attempt_guard #(
        .MAX_ERR    (MAX_ERR),
        .LOCK_CYCLES(LOCK_CYCLES),
        .MAX_LEVEL  (MAX_LEVEL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vif           (vif),
        .admin_clear   (admin_clear),
        .err_count     (err_count),
        .locked        (locked),
        .lock_remaining(lock_remaining),
        .level         (level),
        .alarm         (alarm),
        .rejected      (rejected),
        .state         (state)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model of the guard.
    bit m_locked = 1'b0;
    int m_err = 0;
    int m_level = 0;
    int m_rem = 0;
    bit m_alarm = 1'b0;
    bit m_rej = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] model_vec();
        return {~m_locked, m_locked, CNT_W'(m_err), TMR_W'(m_rem), 2'(m_level), m_alarm, m_rej};
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_err = 0; m_level = 0; m_rem = 0; m_alarm = 1'b0; m_rej = 1'b0;
    endtask

    task automatic compare_outputs(input logic [EXP_W-1:0] e);
        check("ready",    32'(vif.ready),      32'(e[14]));
        check("locked",   32'(locked),         32'(e[13]));
        check("err",      32'(err_count),      32'(e[12:11]));
        check("remain",   32'(lock_remaining), 32'(e[10:4]));
        check("level",    32'(level),          32'(e[3:2]));
        check("alarm",    32'(alarm),          32'(e[1]));
        check("rejected", 32'(rejected),       32'(e[0]));
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, predict the next-edge outputs, then compare.
    task automatic step(input logic v, input logic ok, input logic clr);
        vif.verdict_valid = v;
        vif.verdict_ok    = ok;
        admin_clear       = clr;
        m_alarm = 1'b0;
        m_rej   = 1'b0;
        if (clr) begin
            model_reset();
        end else if (!m_locked) begin
            if (v) begin
                if (ok) begin
                    m_err = 0;
                    m_level = 0;
                end else if (m_err + 1 == MAX_ERR) begin
                    m_err = MAX_ERR;
                    m_locked = 1'b1;
                    m_rem = LOCK_CYCLES << m_level;
                    m_alarm = 1'b1;
                    if (m_level < MAX_LEVEL) m_level++;
                end else begin
                    m_err++;
                end
            end
        end else begin
            m_rej = v;
            if (m_rem == 1) begin
                m_locked = 1'b0;
                m_rem = 0;
                m_err = 0;
            end else begin
                m_rem--;
            end
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        vif.verdict_valid = 1'b0;
        vif.verdict_ok    = 1'b0;
        admin_clear       = 1'b0;
        compare_outputs(exp_q.pop_front());
    endtask

    // Three fails, then idle until the lockout ends; optionally strobe
    // verdicts mid-lockout. Checks the locked duration.
    task automatic run_lockout(input int exp_len, input bit inject);
        int cnt;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cnt = locked ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            if (inject && (i == 2)) step(1'b1, 1'b0, 1'b0);
            else if (inject && (i == 4)) step(1'b1, 1'b1, 1'b0);
            else step(1'b0, 1'b0, 1'b0);
            if (locked) cnt++;
            if (!m_locked) break;
        end
        check("lock_len", 32'(cnt), 32'(exp_len));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        admin_clear = 1'b0;
        vif.verdict_valid = 1'b0;
        vif.verdict_ok = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        compare_outputs(model_vec());

        // fail, fail, pass
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Escalating lockouts, then saturated level.
        run_lockout(8, 1'b0);
        run_lockout(16, 1'b1);
        run_lockout(32, 1'b0);
        run_lockout(64, 1'b1);
        run_lockout(64, 1'b0);
        check("level_sat", 32'(level), 32'(MAX_LEVEL));

        // Verdict in the first ready cycle after lockout is accepted.
        step(1'b1, 1'b0, 1'b0);
        check("first_ready_err", 32'(err_count), 32'd1);

        // admin_clear together with a fail verdict mid-lockout.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("clr_level", 32'(level), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-lockout.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs(model_vec());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_outputs(model_vec());

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 40) == 0));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
